// File: rtl/crypto_keyed_xor_if.sv
`default_nettype none
// ============================================================================
// Module   : crypto_keyed_xor_if
// Brief    : AXI4-Stream bundle (tdata/tkeep/tuser/tvalid/tready/tlast).
// Revision : 1.0 - initial release
// ============================================================================
interface crypto_keyed_xor_if #(
  parameter int DATA_W = 256,
  parameter int USER_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [USER_W-1:0]   tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface
`default_nettype wire

// File: rtl/crypto_keyed_xor.sv
`default_nettype none
// ============================================================================
// Module   : crypto_keyed_xor
// Brief    : Per-packet keyed XOR of an AXI4-Stream, key picked by source port;
//            header bytes pass clear. Optional CRYPTO_KEY_ROTATE_EN rotates the
//            key left by one byte per beat.
// Revision : 1.0 - initial release
// ============================================================================
module crypto_keyed_xor #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int SRC_PORT_POS       = 16,
  parameter int HDR_SKIP_BYTES     = 34,
  parameter int NUM_KEYS           = 4,
  localparam int BW  = C_AXIS_DATA_WIDTH / 8,
  localparam int KIW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  wire logic              axis_aclk,
  input  wire logic              axis_resetn,
  crypto_keyed_xor_if.slave      s_axis,
  crypto_keyed_xor_if.master     m_axis,
  input  wire logic              key_wr_en,
  input  wire logic [KIW-1:0]    key_wr_idx,
  input  wire logic [31:0]       key_wr_data,
  input  wire logic              crypto_en,
  output logic      [31:0]       pkt_count
);

  localparam logic [11:0] C_OFF_SAT = 12'd1024;

  typedef enum logic [0:0] {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [31:0]                     r_key_tbl [NUM_KEYS];
  logic [31:0]                     r_key_sel;
  logic                            r_enc;
  logic [10:0]                     r_offset;
  logic [C_AXIS_DATA_WIDTH-1:0]    r_m_tdata;
  logic [BW-1:0]                   r_m_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]   r_m_tuser;
  logic                            r_m_tvalid;
  logic                            r_m_tlast;
  logic [31:0]                     r_pkt_count;

  logic                            w_s_tready;
  logic                            w_accept;
  logic [7:0]                      w_src_field;
  logic [2:0]                      w_src_pos;
  logic [2:0]                      w_src_mod;
  logic [KIW-1:0]                  w_idx;
  logic [31:0]                     w_key;
  logic                            w_enc;
  logic [10:0]                     w_base;
  logic [11:0]                     w_off_sum;
  logic [10:0]                     w_off_nxt;
  logic [C_AXIS_DATA_WIDTH-1:0]    w_xdata;

  assign w_s_tready = !r_m_tvalid || m_axis.tready;
  assign w_accept   = s_axis.tvalid && w_s_tready;

  assign s_axis.tready = w_s_tready;
  assign m_axis.tdata  = r_m_tdata;
  assign m_axis.tkeep  = r_m_tkeep;
  assign m_axis.tuser  = r_m_tuser;
  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tlast  = r_m_tlast;
  assign pkt_count     = r_pkt_count;

  // Lowest set bit of the one-hot source field wins; an empty field maps to 0.
  assign w_src_field = s_axis.tuser[SRC_PORT_POS +: 8];
  always_comb begin
    w_src_pos = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (w_src_field[i]) w_src_pos = 3'(i);
    end
  end
  assign w_src_mod = w_src_pos & 3'(NUM_KEYS - 1);
  assign w_idx     = w_src_mod[KIW-1:0];

  // The SOP beat uses the table/enable values being latched on this edge.
  always_comb begin
    if (r_state == ST_SOP) begin
      w_key  = r_key_tbl[w_idx];
      w_enc  = crypto_en;
      w_base = '0;
    end else begin
      w_key  = r_key_sel;
      w_enc  = r_enc;
      w_base = r_offset;
    end
  end

  assign w_off_sum = {1'b0, w_base} + 12'(BW);
  assign w_off_nxt = (w_off_sum > C_OFF_SAT) ? C_OFF_SAT[10:0] : w_off_sum[10:0];

  always_comb begin
    w_xdata = s_axis.tdata;
    for (int b = 0; b < BW; b++) begin
      if (w_enc && s_axis.tkeep[b] && (int'(w_base) + b >= HDR_SKIP_BYTES))
        w_xdata[8*b +: 8] = s_axis.tdata[8*b +: 8] ^ w_key[8*(b%4) +: 8];
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) r_state <= ST_SOP;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = s_axis.tlast ? ST_SOP : ST_BODY;
  end

  // In rotate builds r_key_sel always holds the key for the next BODY beat.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_key_sel <= '0;
      r_enc     <= 1'b0;
      r_offset  <= '0;
    end else if (w_accept) begin
      r_offset <= w_off_nxt;
      if (r_state == ST_SOP) r_enc <= crypto_en;
`ifdef CRYPTO_KEY_ROTATE_EN
      r_key_sel <= {w_key[23:0], w_key[31:24]};
`else
      if (r_state == ST_SOP) r_key_sel <= w_key;
`endif
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      for (int i = 0; i < NUM_KEYS; i++) r_key_tbl[i] <= '0;
    end else if (key_wr_en) begin
      r_key_tbl[key_wr_idx] <= key_wr_data;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tdata  <= w_xdata;
      r_m_tkeep  <= s_axis.tkeep;
      r_m_tuser  <= s_axis.tuser;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= s_axis.tlast;
    end else if (m_axis.tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn)
      r_pkt_count <= '0;
    else if (r_m_tvalid && m_axis.tready && r_m_tlast)
      r_pkt_count <= r_pkt_count + 32'd1;
  end

endmodule
`default_nettype wire

// File: tb/tb_crypto_keyed_xor.sv
`default_nettype none
// ============================================================================
// Module   : tb_crypto_keyed_xor
// Brief    : Self-checking bench: directed + random packets against a
//            byte-level reference model of the keyed XOR stream.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_crypto_keyed_xor;
  localparam int DW  = 256;
  localparam int UW  = 128;
  localparam int BW  = 32;
  localparam int HDR = 34;
  localparam int NK  = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [BW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic        axis_aclk   = 1'b0;
  logic        axis_resetn = 1'b0;
  logic        key_wr_en   = 1'b0;
  logic [1:0]  key_wr_idx  = '0;
  logic [31:0] key_wr_data = '0;
  logic        crypto_en   = 1'b0;
  logic [31:0] pkt_count;

  crypto_keyed_xor_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  crypto_keyed_xor_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  crypto_keyed_xor dut (
    .axis_aclk   (axis_aclk),
    .axis_resetn (axis_resetn),
    .s_axis      (s_if.slave),
    .m_axis      (m_if.master),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .crypto_en   (crypto_en),
    .pkt_count   (pkt_count)
  );

  always #5 axis_aclk = ~axis_aclk;

  int            tests = 0;
  int            fails = 0;
  logic [31:0]   mdl_tbl [NK];
  bit            mdl_in_pkt = 0;
  int            mdl_n = 0;
  logic [31:0]   mdl_key = '0;
  bit            mdl_en = 0;
  beat_t         exp_q [$];
  logic [DW-1:0] cap [$];
  int            exp_cnt = 0;
  bit            rdy_rand = 0;
  bit            rdy_script [$];
  logic [DW-1:0] A5 = {32{8'hA5}};
  logic [DW-1:0] Z  = '0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl32(logic [31:0] k, int sh);
    if (sh == 0) return k;
    return (k << sh) | (k >> (32 - sh));
  endfunction

  function automatic int src_idx(logic [UW-1:0] u);
    int idx;
    idx = 0;
    for (int i = 7; i >= 0; i--) if (u[16+i]) idx = i;
    return idx % NK;
  endfunction

  // Packet byte at offset n*BW+b is keyed iff enabled, kept and past the header.
  function automatic logic [DW-1:0] xform(logic [DW-1:0] d, logic [BW-1:0] k,
                                          logic [31:0] key, bit en, int n);
    logic [DW-1:0] r;
    logic [31:0]   kk;
    int            base;
    r    = d;
    kk   = key;
    base = (n * BW > 1024) ? 1024 : n * BW;
`ifdef CRYPTO_KEY_ROTATE_EN
    kk = rotl32(key, 8 * (n % 4));
`endif
    for (int b = 0; b < BW; b++)
      if (en && k[b] && (base + b >= HDR)) r[8*b +: 8] = d[8*b +: 8] ^ kk[8*(b%4) +: 8];
    return r;
  endfunction

  function automatic logic [UW-1:0] usr(logic [7:0] src);
    logic [UW-1:0] u;
    u = '0;
    u[23:16] = src;
    return u;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[32*w +: 32] = $urandom();
    return d;
  endfunction

  task automatic model_accept();
    beat_t e;
    if (!mdl_in_pkt) begin
      mdl_key = mdl_tbl[src_idx(s_if.tuser)];
      mdl_en  = crypto_en;
      mdl_n   = 0;
    end
    e.d = xform(s_if.tdata, s_if.tkeep, mdl_key, mdl_en, mdl_n);
    e.k = s_if.tkeep;
    e.u = s_if.tuser;
    e.l = s_if.tlast;
    exp_q.push_back(e);
    if (s_if.tlast) mdl_in_pkt = 0;
    else begin
      mdl_in_pkt = 1;
      mdl_n++;
    end
  endtask

  // Presents one beat until accepted; leaves tvalid high for back-to-back use.
  task automatic send_beat(logic [DW-1:0] d, logic [BW-1:0] k, logic [UW-1:0] u,
                           bit last, bit en, bit wr = 0, logic [1:0] wi = '0,
                           logic [31:0] wd = '0);
    int t;
    bit done;
    t = 0;
    done = 0;
    s_if.tdata  = d;
    s_if.tkeep  = k;
    s_if.tuser  = u;
    s_if.tlast  = last;
    s_if.tvalid = 1'b1;
    crypto_en   = en;
    key_wr_en   = wr;
    key_wr_idx  = wi;
    key_wr_data = wd;
    while (!done) begin
      @(negedge axis_aclk);
      if (s_if.tready) begin
        model_accept();
        done = 1;
      end
      if (key_wr_en) mdl_tbl[key_wr_idx] = key_wr_data;
      @(posedge axis_aclk);
      #1;
      key_wr_en = 1'b0;
      t++;
      if (!done && t > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        done = 1;
      end
    end
  endtask

  task automatic key_write(logic [1:0] idx, logic [31:0] data);
    s_if.tvalid = 1'b0;
    key_wr_en   = 1'b1;
    key_wr_idx  = idx;
    key_wr_data = data;
    @(negedge axis_aclk);
    mdl_tbl[idx] = data;
    @(posedge axis_aclk);
    #1;
    key_wr_en = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    s_if.tvalid = 1'b0;
    while (exp_q.size() > 0 && t < 500) begin
      @(posedge axis_aclk);
      #1;
      t++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) begin
      @(posedge axis_aclk);
      #1;
    end
  endtask

  task automatic do_reset();
    axis_resetn = 1'b0;
    s_if.tvalid = 1'b0;
    key_wr_en   = 1'b0;
    exp_q.delete();
    exp_cnt     = 0;
    mdl_in_pkt  = 0;
    for (int i = 0; i < NK; i++) mdl_tbl[i] = '0;
    #2;
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_pkt_count", pkt_count, 0);
    repeat (2) @(posedge axis_aclk);
    #1;
    axis_resetn = 1'b1;
  endtask

  // Ready generator: scripted pattern first, else random or always-ready.
  always begin
    @(posedge axis_aclk);
    #1;
    if (rdy_script.size() > 0) m_if.tready = rdy_script.pop_front();
    else if (rdy_rand)         m_if.tready = ($urandom_range(0, 3) != 0);
    else                       m_if.tready = 1'b1;
  end

  // Cycle compare against the model queue.
  always begin
    @(posedge axis_aclk);
    #3;
    if (axis_resetn) begin
      chk("s_tready", s_if.tready, !m_if.tvalid || m_if.tready);
      chk("pkt_count", pkt_count, exp_cnt);
      if (exp_q.size() > 0) begin
        chk("m_tvalid", m_if.tvalid, 1);
        if (m_if.tvalid) begin
          chk("m_tdata", m_if.tdata, exp_q[0].d);
          chk("m_meta", {m_if.tkeep, m_if.tuser, m_if.tlast},
              {exp_q[0].k, exp_q[0].u, exp_q[0].l});
          if (m_if.tready) begin
            cap.push_back(m_if.tdata);
            if (m_if.tlast) exp_cnt++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        chk("m_tvalid_idle", m_if.tvalid, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] ins [4];
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0;
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; m_if.tready = 1'b1;
    for (int i = 0; i < NK; i++) mdl_tbl[i] = '0;
    @(posedge axis_aclk);
    #1;
    do_reset();
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_s_tready", s_if.tready, 1);

    // Single-key encrypt
    key_write(2'd0, 32'hFFFFFFFF);
    cap.delete();
    send_beat(A5, '1, usr(8'h01), 0, 1);
    send_beat(A5, '1, usr(8'h01), 0, 1);
    send_beat(A5, '1, usr(8'h01), 1, 1);
    drain();
    chk("enc_beats", cap.size(), 3);
    chk("enc_beat0", cap[0], A5);
    chk("enc_beat1", cap[1], {{30{8'h5A}}, 16'hA5A5});
    chk("enc_beat2", cap[2], {32{8'h5A}});
    chk("enc_count", pkt_count, 1);

    // Key select
    key_write(2'd1, 32'h11223344);
    cap.delete();
    send_beat(Z, '1, usr(8'h02), 0, 1);
    send_beat(Z, '1, usr(8'h02), 1, 1);
    send_beat(Z, '1, usr(8'h00), 0, 1);
    send_beat(Z, '1, usr(8'h00), 1, 1);
    drain();
    v = cap[1];
    chk("ksel_byte1", v[15:8], 8'h00);
    chk("ksel_byte2", v[23:16], 8'h22);
    chk("ksel_byte3", v[31:24], 8'h11);
    chk("ksel_byte4", v[39:32], 8'h44);
    v = cap[3];
    chk("ksel_zero_src", v[23:16], 8'hFF);

    // Bypass, then partial tkeep on the last beat
    cap.delete();
    for (int i = 0; i < 3; i++) begin
      ins[i] = rnd_data();
      send_beat(ins[i], '1, usr(8'h01), i == 2, 0);
    end
    drain();
    for (int i = 0; i < 3; i++) chk("bypass", cap[i], ins[i]);
    cap.delete();
    send_beat(A5, '1, usr(8'h01), 0, 1);
    send_beat(A5, '1, usr(8'h01), 0, 1);
    send_beat(A5, 32'h0000000F, usr(8'h01), 1, 1);
    drain();
    chk("tkeep_last", cap[2], {{28{8'hA5}}, {4{8'h5A}}});

    // Backpressure 1,0,0,1 during a 4-beat stream
    @(negedge axis_aclk);
    rdy_script = '{1'b1, 1'b0, 1'b0, 1'b1};
    @(posedge axis_aclk);
    #1;
    cap.delete();
    for (int i = 0; i < 4; i++) begin
      ins[i] = rnd_data();
      send_beat(ins[i], '1, usr(8'h04), i == 3, 0);
    end
    drain();
    chk("bp_beats", cap.size(), 4);
    for (int i = 0; i < 4; i++) chk("bp_data", cap[i], ins[i]);

    // Key write mid-packet
    cap.delete();
    send_beat(A5, '1, usr(8'h01), 0, 1);
    send_beat(A5, '1, usr(8'h01), 0, 1, 1, 2'd0, 32'h0F0F0F0F);
    send_beat(A5, '1, usr(8'h01), 1, 1);
    send_beat(A5, '1, usr(8'h01), 0, 1);
    send_beat(A5, '1, usr(8'h01), 1, 1);
    drain();
    chk("kw_old_key", cap[2], {32{8'h5A}});
    v = cap[4];
    chk("kw_new_key", v[23:16], 8'hAA);

    // Reset mid-packet
    send_beat(A5, '1, usr(8'h01), 0, 1);
    send_beat(A5, '1, usr(8'h01), 0, 1);
    do_reset();
    key_write(2'd0, 32'hFFFFFFFF);
    cap.delete();
    send_beat(A5, '1, usr(8'h01), 1, 1);
    drain();
    chk("post_rst_sop", cap[0], A5);
    chk("post_rst_count", pkt_count, 1);

`ifdef CRYPTO_KEY_ROTATE_EN
    key_write(2'd0, 32'h000000FF);
    cap.delete();
    send_beat(Z, '1, usr(8'h01), 0, 1);
    send_beat(Z, '1, usr(8'h01), 0, 1);
    send_beat(Z, '1, usr(8'h01), 1, 1);
    drain();
    v = cap[1];
    chk("rot_b1_byte23", v[31:16], 16'h0000);
    chk("rot_b1_byte5", v[47:40], 8'hFF);
    v = cap[2];
    chk("rot_b2_byte2", v[23:16], 8'hFF);
`endif

    // Randomized traffic
    rdy_rand = 1;
    for (int p = 0; p < 150; p++) begin
      int len;
      bit en;
      logic [7:0] src;
      len = $urandom_range(1, 5);
      en  = ($urandom_range(0, 3) != 0);
      src = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom());
      for (int b = 0; b < len; b++) begin
        logic [BW-1:0] k;
        k = ($urandom_range(0, 1) == 0) ? '1 : $urandom();
        send_beat(rnd_data(), k, usr(src) | UW'($urandom()), b == len - 1, en,
                  $urandom_range(0, 7) == 0, 2'($urandom()), $urandom());
      end
      if ($urandom_range(0, 3) == 0) begin
        s_if.tvalid = 1'b0;
        @(posedge axis_aclk);
        #1;
      end
    end
    drain();
    rdy_rand = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
